// File: rtl/hex_scan_pkg.sv
// Shared types, the 7-segment hex font and the pin-polarity helper for the
// multiplexed hex display driver.
package hex_scan_pkg;

  typedef logic [6:0] seg7_t;

  // Bit order within each entry: g f e d c b a (bit6..bit0).
  localparam seg7_t HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71
  };

  function automatic seg7_t seg_pol(seg7_t s, bit active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/hex_font_lut.sv
// Combinational nibble to 7-segment pattern lookup on the shared hex font.
module hex_font_lut
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed multi-digit hex 7-segment scanner with double-buffered data.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_display
  import hex_scan_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam bit               POL       = (ACTIVE_LOW != 0);
  localparam seg7_t            SEG_OFF   = seg_pol(7'h00, POL);

  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [4*DIGITS-1:0] stage_val, shadow_val;
  logic [DIGITS-1:0]   stage_dp, shadow_dp;
  logic                pend_flag;
  logic                fb;

  assign fb = (div_cnt == DIV_LAST) && (dig_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses staging so it is
  // shown in the very next frame and never raises pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_val  <= '0;
      stage_dp   <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_flag  <= 1'b0;
    end else begin
      if (load) begin
        stage_val <= value;
        stage_dp  <= dp;
      end
      if (fb) begin
        if (load) begin
          shadow_val <= value;
          shadow_dp  <= dp;
        end else if (pend_flag) begin
          shadow_val <= stage_val;
          shadow_dp  <= stage_dp;
        end
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [DIGITS-1:0] sel_onehot;
  logic              cur_blank;
  logic              slot_blank;
  seg7_t             font_seg;

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    sel_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_idx == IDX_W'(k)) begin
        cur_nib       = shadow_val[4*k +: 4];
        cur_dp        = shadow_dp[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

`ifdef HEX_SCAN_LZB_EN
  logic [DIGITS-1:0] lead_zero;
  logic              lz_run;

  // Scan from the most significant digit down; digit 0 always shows.
  always_comb begin
    lz_run    = 1'b1;
    lead_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run       = lz_run && (shadow_val[4*k +: 4] == 4'h0);
      lead_zero[k] = lz_run && (k != 0);
    end
  end

  assign cur_blank = |(lead_zero & sel_onehot);
`else
  assign cur_blank = 1'b0;
`endif

  assign slot_blank = (div_cnt < BLANK_END);

  hex_font_lut u_font (
    .nibble (cur_nib),
    .seg    (font_seg)
  );

  logic [6:0]        seg_p1;
  logic              dp_p1;
  logic [DIGITS-1:0] sel_p1;
  logic              tick_p1;

  // Output register stage: pins lag the counter state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1  <= SEG_OFF;
      dp_p1   <= POL;
      sel_p1  <= {DIGITS{POL}};
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= fb;
      if (slot_blank) begin
        seg_p1 <= SEG_OFF;
        dp_p1  <= POL;
        sel_p1 <= {DIGITS{POL}};
      end else begin
        seg_p1 <= seg_pol(cur_blank ? 7'h00 : font_seg, POL);
        dp_p1  <= cur_dp ^ POL;
        sel_p1 <= sel_onehot ^ {DIGITS{POL}};
      end
    end
  end

  assign seg        = seg_p1;
  assign seg_dp     = dp_p1;
  assign dig_sel    = sel_p1;
  assign pending    = pend_flag;
  assign frame_tick = tick_p1;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: expected per-digit pin words are
// queued when data is loaded and compared across the following frame.
module tb_hex_scan_display;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  parameter  int ACTIVE_LOW = 0;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  dig_sel;
  logic        pending;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  hex_scan_display #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .seg        (seg),
    .seg_dp     (seg_dp),
    .dig_sel    (dig_sel),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] blank_word();
    return (ACTIVE_LOW != 0) ? 12'hFFF : 12'h000;
  endfunction

  function automatic logic [11:0] exp_slot(logic [15:0] v, logic [3:0] d, int k);
    logic [6:0]  s;
    logic [15:0] up;
    logic [3:0]  sel;
    logic [11:0] w;
    s  = FONT[v[4*k +: 4]];
    up = v >> (4 * k);
`ifdef HEX_SCAN_LZB_EN
    if (k > 0 && up == 16'h0) s = 7'h00;
`endif
    sel = 4'b0001 << k;
    w = {s, d[k], sel};
    if (ACTIVE_LOW != 0) w = ~w;
    return w;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    exp_q.delete();
    for (int k = 0; k < DIGITS; k++) exp_q.push_back(exp_slot(v, d, k));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    push_frame(v, d);
    step();
    load  = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tick: frame_tick not seen within 100 cycles");
    end
  endtask

  // Call right after the frame_tick cycle: samples the next 32 pin states.
  task automatic check_frame(input string name);
    logic [11:0] e, ex, got;
    for (int k = 0; k < DIGITS; k++) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: scoreboard empty at digit %0d", name, k);
        return;
      end
      e = exp_q.pop_front();
      for (int j = 0; j < SCAN_DIV; j++) begin
        step();
        got = {seg, seg_dp, dig_sel};
        ex  = (j < BLANK_CYC) ? blank_word() : e;
        vectors++;
        if (got !== ex) begin
          miscompares++;
          $display("FAIL %s digit %0d cyc %0d: got %h expected %h", name, k, j, got, ex);
        end
      end
    end
  endtask

  task automatic test_reset();
    int first_tick;
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if ({seg, seg_dp, dig_sel} !== blank_word() || pending !== 1'b0 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got pins %h pending %b tick %b expected %h 0 0",
               {seg, seg_dp, dig_sel}, pending, frame_tick, blank_word());
    end
    rst_n = 1'b1;
    first_tick = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 2) begin
        vectors++;
        if ({seg, seg_dp, dig_sel} !== blank_word()) begin
          miscompares++;
          $display("FAIL first_gap: got %h expected %h", {seg, seg_dp, dig_sel}, blank_word());
        end
      end
      if (n == 3) begin
        vectors++;
        if ({seg, seg_dp, dig_sel} !== exp_slot(16'h0, 4'h0, 0)) begin
          miscompares++;
          $display("FAIL first_visible: got %h expected %h", {seg, seg_dp, dig_sel}, exp_slot(16'h0, 4'h0, 0));
        end
      end
      if (frame_tick === 1'b1 && first_tick < 0) first_tick = n;
    end
    vectors++;
    if (first_tick != 32) begin
      miscompares++;
      $display("FAIL first_tick: got cycle %0d expected 32", first_tick);
    end
  endtask

  task automatic test_load_basic();
    bit ok;
    do_load(16'h8A3F, 4'b0100);
    wait_tick(ok);
    if (ok) check_frame("basic_8A3F");
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    wait_tick(ok);
    do_load(16'h1111, 4'b0000);
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_rise: got %b expected 1", pending);
    end
    step();
    step();
    do_load(16'h2222, 4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        if (pending !== 1'b0) begin
          miscompares++;
          $display("FAIL pending_fall: got %b expected 0", pending);
        end
        break;
      end else if (pending !== 1'b1) begin
        miscompares++;
        $display("FAIL pending_hold cyc %0d: got %b expected 1", i, pending);
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL b2b_tick: frame_tick not seen");
    end else begin
      check_frame("b2b_2222");
    end
  endtask

  task automatic test_load_at_fb();
    bit ok;
    wait_tick(ok);
    for (int i = 0; i < 31; i++) step();
    value = 16'hABCD;
    dp    = 4'b0000;
    load  = 1'b1;
    push_frame(16'hABCD, 4'b0000);
    step();
    load = 1'b0;
    vectors++;
    if (frame_tick !== 1'b1 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL fb_load: got tick %b pending %b expected 1 0", frame_tick, pending);
    end
    check_frame("fb_ABCD");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cnt;
    wait_tick(ok);
    step();
    step();
    do_load(16'h5555, 4'b1111);
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pending: got %b expected 1", pending);
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({seg, seg_dp, dig_sel} !== blank_word() || pending !== 1'b0 || frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got pins %h pending %b tick %b expected %h 0 0",
               {seg, seg_dp, dig_sel}, pending, frame_tick, blank_word());
    end
    step();
    step();
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000);
    cnt = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (frame_tick === 1'b1) begin
        cnt = i;
        ok  = 1'b1;
        break;
      end
    end
    vectors++;
    if (cnt != 32) begin
      miscompares++;
      $display("FAIL mid_tick: got cycle %0d expected 32", cnt);
    end
    if (ok) check_frame("after_reset_zero");
  endtask

  task automatic test_lzb();
    bit ok;
    do_load(16'h0050, 4'b0000);
    wait_tick(ok);
    if (ok) check_frame("lzb_0050");
    do_load(16'h0000, 4'b0000);
    wait_tick(ok);
    if (ok) check_frame("lzb_0000");
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_load_at_fb();
    test_reset_mid();
    test_lzb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Multiplexed multi-digit 7-segment driver. Scans `DIGITS` hexadecimal digits onto one shared segment bus with a one-hot digit-enable, using a programmable per-digit dwell and an anti-ghosting blank gap. Display data is double-buffered and swapped only at frame boundaries, so the display never tears. It sits between status/debug registers and the board's common-anode or common-cathode display pins. It supersedes per-digit single-decoder instances.

## Interface
- `DIGITS`, 4: number of digits scanned, 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 16: cycles at the start of each slot with all digits disabled; must be < `SCAN_DIV`.
- `ACTIVE_LOW`, 0: when 1, `seg`, `seg_dp` and `dig_sel` are inverted at the pins.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 4*DIGITS: nibble k is digit k; digit 0 is the least significant.
- `dp` in DIGITS: decimal-point request per digit.
- `load` in 1: single-cycle strobe that captures `value` and `dp`.
- `seg` out 7: segments, bit0 = a … bit6 = g, before polarity.
- `seg_dp` out 1: decimal point.
- `dig_sel` out DIGITS: one-hot digit enable.
- `pending` out 1: a captured value is waiting for a frame boundary.
- `frame_tick` out 1: one-cycle pulse at each frame wrap.

## Operation
- Counters:
  - `div_cnt` runs 0..SCAN_DIV-1.
  - `dig_idx` runs 0..DIGITS-1 and advances when `div_cnt` wraps.
  - Frame boundary (FB) = the cycle in which `div_cnt` = SCAN_DIV-1 and `dig_idx` = DIGITS-1.
- Buffering:
  - On `load`, `value`/`dp` are written to the staging register and `pending` is set.
  - A second `load` before the FB overwrites the staging register; last write wins.
  - At the FB, if `pending` is set or `load` is high, the shadow register takes the staging contents. A `load` in the FB cycle itself is forwarded directly to the shadow. `pending` clears.
  - `frame_tick` asserts in the cycle after the FB.
- Decode: the shadow nibble at `dig_idx` maps through the hex font:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=7B, F=71 (hex, bit6..0 = g..a).
- Gating:
  - While `div_cnt` < BLANK_CYC, `dig_sel` is all-inactive and `seg`/`seg_dp` are forced inactive.
  - Otherwise `dig_sel` has bit `dig_idx` active, and `seg`/`seg_dp` carry the font value and the shadow `dp` bit.
- Reset:
  - `div_cnt` = 0, `dig_idx` = 0, staging = shadow = 0, `pending` = 0.
  - All outputs are inactive: 0 when `ACTIVE_LOW` = 0, all-ones when `ACTIVE_LOW` = 1. `frame_tick` is 0.
  - Reset mid-frame discards any pending load.
- `DIGITS` = 1: every slot end is an FB.

## Timing
- All outputs are registered. Pin state in cycle n+1 reflects the counter state in cycle n, giving one cycle of latency.
- Each digit is visible for SCAN_DIV-BLANK_CYC cycles per slot. A frame is DIGITS*SCAN_DIV cycles.
- `load` → shadow:
  - Worst case one full frame.
  - Best case 0 cycles, when `load` coincides with the FB.
  - The new value appears at the pins from the first non-blank cycle of digit 0 in the next frame.
- `pending` rises the cycle after `load` and falls the cycle after the FB.
- The first frame after reset starts at `dig_idx` 0. The first non-blank output appears at cycle BLANK_CYC+1.

## Configuration
- `HEX_SCAN_LZB_EN` defined enables leading-zero blanking:
  - Digit k > 0 whose shadow nibble and all more-significant nibbles are 0 shows `seg` inactive; `seg_dp` still follows `dp`.
  - Digit 0 is never blanked.
  - The blanking decision uses the shadow only.
- Macro undefined: every digit always shows its font value.

## Structure
- Package `hex_scan_pkg`:
  - `seg7_t` (logic [6:0]).
  - 16-entry font constant `HEX_FONT`.
  - Function `seg_pol(seg7_t, bit active_low)`.
- Sub-module `hex_font_lut`: combinational nibble→`seg7_t` lookup on `HEX_FONT`.
- The top level holds the counters, buffers, gating and output registers.

## Test plan
All cases use `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYC`=2, `ACTIVE_LOW`=0 unless stated.
- Reset, then `load` `value`=16'h8A3F, `dp`=4'b0100:
  - After the first FB, the digit 0..3 non-blank windows show `seg` 71, 4F, 77, 7F.
  - `seg_dp` is high only during digit 2.
  - `dig_sel` = 0001/0010/0100/1000, each for 6 cycles after a 2-cycle all-zero gap.
- Two `load`s in one frame (1111 then 2222):
  - Only 2222 appears after the FB.
  - `pending` is high from the first load to the FB.
- `load` of 16'hABCD in exactly the FB cycle:
  - Digit 0 shows 5E in the immediately following frame.
  - `pending` never asserts.
- Assert `rst_n` low mid-slot with a load pending:
  - All outputs go to 0 asynchronously and `pending` = 0.
  - After release, the shadow is 0 (digits show 3F), and `frame_tick` first pulses 32 cycles after reset release.
- `HEX_SCAN_LZB_EN` defined, `value`=16'h0050:
  - Digits 3 and 2 are blank; digits 1 and 0 show 6D and 3F.
  - With `value`=0, only digit 0 shows 3F.
- `ACTIVE_LOW`=1: all outputs are the bitwise complement of the `ACTIVE_LOW`=0 run, including the reset values (all ones).
